// File: rtl/servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servo_pkg                                                                  |
// | Shared constants, scheduler state type and pulse-width clamp helper.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package servo_pkg;

    localparam int FRAME_TICKS = 20000;
    localparam int CNT_W       = 15;
    localparam int PW_MIN      = 1000;
    localparam int PW_MAX      = 2000;
    localparam int PW_INIT     = 1500;
    localparam int STEP        = 10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    function automatic int unsigned clamp_u(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_ramp_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servo_ramp_scheduler_if                                                    |
// | Valid/ready command port carrying a channel index and a target width.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface servo_ramp_scheduler_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 15
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [CNT_W-1:0] cmd_target;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_target,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_target,
        output cmd_ready
    );

endinterface
`default_nettype wire

// File: rtl/servo_pwm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servo_pwm_channel                                                          |
// | One servo: live position register, bounded slew step, registered PWM.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module servo_pwm_channel #(
    parameter int CNT_W   = servo_pkg::CNT_W,
    parameter int PW_INIT = servo_pkg::PW_INIT,
    parameter int STEP    = servo_pkg::STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step_en,
    input  logic [CNT_W-1:0] i_tgt,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] o_pos,
    output logic             o_pwm
);

    localparam logic [CNT_W-1:0] c_init = CNT_W'(PW_INIT);
    localparam logic [CNT_W-1:0] c_step = CNT_W'(STEP);

    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] w_pos_nxt;
    logic             r_pwm;

    // Move at most one step, landing exactly on the target when closer than that.
    always_comb begin
        w_pos_nxt = r_pos;
        if (r_pos < i_tgt) begin
            w_pos_nxt = ((i_tgt - r_pos) > c_step) ? (r_pos + c_step) : i_tgt;
        end else if (r_pos > i_tgt) begin
            w_pos_nxt = ((r_pos - i_tgt) > c_step) ? (r_pos - c_step) : i_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= c_init;
            r_pwm <= 1'b0;
        end else begin
            if (i_step_en) begin
                r_pos <= w_pos_nxt;
            end
            r_pwm <= (i_cnt < r_pos);
        end
    end

    assign o_pos = r_pos;
    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/servo_ramp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servo_ramp_scheduler                                                       |
// | Shared PWM frame, command-driven targets, per-frame slew in the dead tail. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module servo_ramp_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int FRAME_TICKS = servo_pkg::FRAME_TICKS,
    parameter int CNT_W       = servo_pkg::CNT_W,
    parameter int PW_MIN      = servo_pkg::PW_MIN,
    parameter int PW_MAX      = servo_pkg::PW_MAX,
    parameter int PW_INIT     = servo_pkg::PW_INIT,
    parameter int STEP        = servo_pkg::STEP,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   mclk,
    input  logic                   rst,
    servo_ramp_scheduler_if.slave  cmd,
    input  logic                   freeze,
    output logic [NUM_CH-1:0]      pwm,
    output logic                   frame_start,
    output logic [NUM_CH-1:0]      busy
);

    import servo_pkg::*;

    localparam logic [CNT_W-1:0] c_last      = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] c_upd_start = CNT_W'(FRAME_TICKS - 1 - NUM_CH);
    localparam logic [CH_W-1:0]  c_last_idx  = CH_W'(NUM_CH - 1);

    if (!(PW_MAX < FRAME_TICKS - NUM_CH - 2)) begin : g_chk_pw_max
        $error("PW_MAX must be below FRAME_TICKS-NUM_CH-2");
    end
    if (!((PW_MIN <= PW_INIT) && (PW_INIT <= PW_MAX))) begin : g_chk_pw_init
        $error("PW_INIT must lie within [PW_MIN, PW_MAX]");
    end
    if (!(STEP >= 1)) begin : g_chk_step
        $error("STEP must be at least 1");
    end
    if (!(longint'(FRAME_TICKS) <= (longint'(1) << CNT_W))) begin : g_chk_cnt_w
        $error("FRAME_TICKS does not fit in CNT_W bits");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_idx;
    logic [CH_W-1:0]     w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_frame_start;
    logic [CNT_W-1:0]    r_tgt [NUM_CH];
    logic [CNT_W-1:0]    w_pos [NUM_CH];
    logic [NUM_CH-1:0]   r_busy;
    logic [NUM_CH-1:0]   w_step_en;
    logic [NUM_CH-1:0]   w_pwm;
    logic                w_accept;
    logic                w_ch_legal;
    logic [CNT_W-1:0]    w_cmd_tgt;

    assign cmd.cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
    assign w_ch_legal    = (32'(cmd.cmd_ch) < NUM_CH);
    assign w_cmd_tgt     = CNT_W'(clamp_u(32'(cmd.cmd_target), PW_MIN, PW_MAX));

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= (r_cnt == c_last) ? '0 : (r_cnt + CNT_W'(1));
            r_frame_start <= (r_cnt == '0);
        end
    end

    // The sweep ends on the last counter value, so positions settle before the next frame.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_step_en   = '0;
        case (r_state)
            IDLE: begin
                if (r_cnt == c_upd_start) begin
                    w_state_nxt = UPDATE;
                    w_idx_nxt   = '0;
                end
            end
            UPDATE: begin
                w_step_en[r_idx] = !freeze;
                if (r_idx == c_last_idx) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_idx_nxt = r_idx + CH_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_tgt[i] <= CNT_W'(PW_INIT);
            end
            r_busy <= '0;
        end else begin
            if (w_accept && w_ch_legal) begin
                r_tgt[cmd.cmd_ch] <= w_cmd_tgt;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_busy[i] <= (w_pos[i] != r_tgt[i]);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_pwm_channel #(
            .CNT_W   (CNT_W),
            .PW_INIT (PW_INIT),
            .STEP    (STEP)
        ) u_ch (
            .clk       (mclk),
            .rst       (rst),
            .i_step_en (w_step_en[g]),
            .i_tgt     (r_tgt[g]),
            .i_cnt     (r_cnt),
            .o_pos     (w_pos[g]),
            .o_pwm     (w_pwm[g])
        );
    end

    assign pwm         = w_pwm;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_servo_ramp_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_servo_ramp_scheduler                                                    |
// | Frame-level reference model of targets and positions against the DUT.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_servo_ramp_scheduler;

    localparam int NUM_CH  = 4;
    localparam int F       = 2200;
    localparam int CNT_W   = 15;
    localparam int CH_W    = 2;
    localparam int PW_MIN  = 1000;
    localparam int PW_MAX  = 2000;
    localparam int PW_INIT = 1500;
    localparam int STEP    = 10;

    typedef struct {
        int t;
        int ch;
        int tgt;
    } cmd_t;

    logic              mclk = 1'b0;
    logic              rst = 1'b1;
    logic              freeze = 1'b0;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] busy;
    logic              frame_start;

    servo_ramp_scheduler_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cmd_bus ();

    servo_ramp_scheduler #(
        .NUM_CH      (NUM_CH),
        .FRAME_TICKS (F)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .cmd         (cmd_bus),
        .freeze      (freeze),
        .pwm         (pwm),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 mclk = ~mclk;

    int   mpos [NUM_CH];
    int   mtgt [NUM_CH];
    bit   exp_busy_q [NUM_CH];
    int   last_w [NUM_CH];
    int   last_acc_t;
    cmd_t cq [$];
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic int clamp_pw(input int v);
        return (v < PW_MIN) ? PW_MIN : ((v > PW_MAX) ? PW_MAX : v);
    endfunction

    function automatic int slew(input int p, input int t);
        if (p < t) return (p + STEP < t) ? p + STEP : t;
        if (p > t) return (p - STEP > t) ? p - STEP : t;
        return p;
    endfunction

    // Runs ncyc cycles of a frame starting at the negedge where frame_start is high.
    task automatic run_frame(input int ncyc);
        int w_exp [NUM_CH];
        int hi [NUM_CH];
        int shape_err [NUM_CH];
        int fs_err = 0;
        int rdy_err = 0;
        int busy_err = 0;
        bit exp_rdy;
        for (int i = 0; i < NUM_CH; i++) begin
            w_exp[i] = mpos[i];
            hi[i] = 0;
            shape_err[i] = 0;
        end
        last_acc_t = -1;
        for (int t = 0; t < ncyc; t++) begin
            if (frame_start !== (t == 0)) fs_err++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pwm[i] === 1'b1) hi[i]++;
                if (pwm[i] !== (t < w_exp[i])) shape_err[i]++;
                if (busy[i] !== exp_busy_q[i]) busy_err++;
                exp_busy_q[i] = (mpos[i] != mtgt[i]);
            end
            if (cq.size() > 0 && cq[0].t <= t) begin
                cmd_bus.cmd_valid  = 1'b1;
                cmd_bus.cmd_ch     = CH_W'(cq[0].ch);
                cmd_bus.cmd_target = CNT_W'(cq[0].tgt);
            end else begin
                cmd_bus.cmd_valid = 1'b0;
            end
            #1;
            exp_rdy = !(t >= F - NUM_CH - 1 && t <= F - 2);
            if (cmd_bus.cmd_ready !== exp_rdy) rdy_err++;
            if (cmd_bus.cmd_valid && cmd_bus.cmd_ready === 1'b1) last_acc_t = t;
            if (cmd_bus.cmd_valid && exp_rdy) begin
                if (cq[0].ch < NUM_CH) mtgt[cq[0].ch] = clamp_pw(cq[0].tgt);
                void'(cq.pop_front());
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (t == F - NUM_CH - 1 + k && !freeze) mpos[k] = slew(mpos[k], mtgt[k]);
            end
            @(negedge mclk);
        end
        cmd_bus.cmd_valid = 1'b0;
        foreach (cq[j]) cq[j].t = 0;
        n_checks++;
        if (fs_err !== 0) $display("FAIL frame_start: %0d cycles wrong, expected 0", fs_err);
        else n_pass++;
        for (int i = 0; i < NUM_CH; i++) begin
            last_w[i] = hi[i];
            n_checks++;
            if (hi[i] !== w_exp[i] || shape_err[i] !== 0)
                $display("FAIL pwm_width ch%0d: got %0d cycles (%0d misplaced), expected %0d",
                         i, hi[i], shape_err[i], w_exp[i]);
            else n_pass++;
        end
        n_checks++;
        if (rdy_err !== 0) $display("FAIL cmd_ready: %0d cycles wrong, expected 0", rdy_err);
        else n_pass++;
        n_checks++;
        if (busy_err !== 0) $display("FAIL busy: %0d samples wrong, expected 0", busy_err);
        else n_pass++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cmd_bus.cmd_valid = 1'b0;
        #1;
        n_checks++;
        if (cmd_bus.cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b, expected 0", cmd_bus.cmd_ready);
        else n_pass++;
        @(negedge mclk);
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            mpos[i] = PW_INIT;
            mtgt[i] = PW_INIT;
            exp_busy_q[i] = 1'b0;
        end
        cq.delete();
        #1;
        n_checks++;
        if (pwm !== '0 || busy !== '0 || frame_start !== 1'b0 || cmd_bus.cmd_ready !== 1'b1)
            $display("FAIL reset_state: pwm=%b busy=%b fs=%b rdy=%b, expected 0000 0000 0 1",
                     pwm, busy, frame_start, cmd_bus.cmd_ready);
        else n_pass++;
        @(negedge mclk);
    endtask

    task automatic test_reset();
        apply_reset();
        run_frame(F);
        run_frame(F);
    endtask

    task automatic test_ramp_freeze();
        for (int f = 0; f < 14; f++) begin
            freeze = (f >= 3 && f <= 5);
            if (f == 0) cq.push_back('{t: 100, ch: 1, tgt: 1600});
            run_frame(F);
            if (f == 0) begin
                n_checks++;
                if (busy[1] !== 1'b1) $display("FAIL ramp_busy_set: got %b, expected 1", busy[1]);
                else n_pass++;
            end
            if (f == 5) begin
                n_checks++;
                if (last_w[1] !== 1530) $display("FAIL freeze_hold: got %0d, expected 1530", last_w[1]);
                else n_pass++;
            end
            if (f == 7) begin
                n_checks++;
                if (last_w[1] !== 1540) $display("FAIL freeze_resume: got %0d, expected 1540", last_w[1]);
                else n_pass++;
            end
        end
        freeze = 1'b0;
        n_checks++;
        if (last_w[1] !== 1600 || busy[1] !== 1'b0 || last_w[0] !== 1500)
            $display("FAIL ramp_final: ch1 %0d busy %b ch0 %0d, expected 1600 0 1500",
                     last_w[1], busy[1], last_w[0]);
        else n_pass++;
    endtask

    task automatic test_clamp();
        cq.push_back('{t: 50, ch: 0, tgt: 2500});
        cq.push_back('{t: 60, ch: 2, tgt: 0});
        cq.push_back('{t: 70, ch: 3, tgt: 1505});
        run_frame(F);
        run_frame(F);
        n_checks++;
        if (last_w[0] !== 1510 || last_w[2] !== 1490 || last_w[3] !== 1505)
            $display("FAIL clamp_first_step: got %0d/%0d/%0d, expected 1510/1490/1505",
                     last_w[0], last_w[2], last_w[3]);
        else n_pass++;
        run_frame(F);
        n_checks++;
        if (last_w[3] !== 1505 || busy !== 4'b0101)
            $display("FAIL clamp_landing: ch3 %0d busy %b, expected 1505 0101", last_w[3], busy);
        else n_pass++;
    endtask

    task automatic test_handshake();
        cq.push_back('{t: 100, ch: 0, tgt: 1200});
        cq.push_back('{t: 200, ch: 0, tgt: 1800});
        cq.push_back('{t: F - NUM_CH - 1, ch: 2, tgt: 1700});
        run_frame(F);
        n_checks++;
        if (last_acc_t !== F - 1) $display("FAIL held_accept: got t=%0d, expected t=%0d", last_acc_t, F - 1);
        else n_pass++;
        run_frame(F);
        n_checks++;
        if (last_w[0] !== 1540 || last_w[2] !== 1460)
            $display("FAIL last_wins: got %0d/%0d, expected 1540/1460", last_w[0], last_w[2]);
        else n_pass++;
        run_frame(F);
        n_checks++;
        if (last_w[2] !== 1470) $display("FAIL held_target: got %0d, expected 1470", last_w[2]);
        else n_pass++;
    endtask

    task automatic test_random();
        int t0;
        for (int f = 0; f < 5; f++) begin
            freeze = ($urandom_range(0, 3) == 0);
            t0 = 0;
            for (int c = 0; c < 3; c++) begin
                t0 = t0 + $urandom_range(1, 700);
                cq.push_back('{t: t0, ch: $urandom_range(0, NUM_CH - 1), tgt: $urandom_range(800, 2300)});
            end
            run_frame(F);
        end
        freeze = 1'b0;
    endtask

    task automatic test_reset_mid();
        cq.push_back('{t: 10, ch: 3, tgt: 1800});
        run_frame(F);
        run_frame(F - 3);
        apply_reset();
        run_frame(F);
        n_checks++;
        if (last_w[3] !== PW_INIT || busy !== '0)
            $display("FAIL reset_mid: ch3 %0d busy %b, expected %0d 0000", last_w[3], busy, PW_INIT);
        else n_pass++;
    endtask

    initial begin
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_ch     = '0;
        cmd_bus.cmd_target = '0;
        test_reset();
        test_ramp_freeze();
        test_clamp();
        test_handshake();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #(1_000_000 * 10);
        $display("FAIL timeout: simulation exceeded 1000000 cycles, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
